// File: rtl/_serializer32.sv
// Parallel-in/serial-out transmitter for 32-bit words. A one-word holding
// buffer lets the next word be queued while the current one shifts out.
module _serializer32 #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        ser_valid,
   output logic        ser_out,
   output logic        ser_last,
   input  logic        ser_ready,
   output logic        busy,
   output logic        o_dbg_state
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_shreg, w_shreg_nxt;
   logic [31:0] r_hold, w_hold_nxt;
   logic [4:0]  r_cnt, w_cnt_nxt;
   logic        r_hold_full, w_hold_full_nxt;

   logic        w_in_xfer;
   logic        w_out_xfer;
   logic        w_out_bit;
   logic [31:0] w_shifted;

   // Valid/ready: a transfer occurs on the rising edge where valid and ready
   // are both high; valid/data must stay stable until then, and ready never
   // depends combinationally on valid.
   assign w_in_xfer  = in_valid & ~r_hold_full;
   assign w_out_xfer = (r_state == S_SHIFT) & ser_ready;
   assign w_out_bit  = MSB_FIRST ? r_shreg[31] : r_shreg[0];
   assign w_shifted  = MSB_FIRST ? {r_shreg[30:0], 1'b0} : {1'b0, r_shreg[31:1]};

   assign in_ready    = ~r_hold_full;
   assign ser_valid   = (r_state == S_SHIFT);
   assign ser_out     = (r_state == S_SHIFT) & w_out_bit;
   assign ser_last    = (r_state == S_SHIFT) & (r_cnt == 5'd31);
   assign busy        = (r_state == S_SHIFT) | r_hold_full;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_shreg     <= 32'd0;
         r_hold      <= 32'd0;
         r_cnt       <= 5'd0;
         r_hold_full <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shreg     <= w_shreg_nxt;
         r_hold      <= w_hold_nxt;
         r_cnt       <= w_cnt_nxt;
         r_hold_full <= w_hold_full_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_shreg_nxt     = r_shreg;
      w_hold_nxt      = r_hold;
      w_cnt_nxt       = r_cnt;
      w_hold_full_nxt = r_hold_full;
      case (r_state)
         S_IDLE: begin
            if (w_in_xfer) begin
               w_shreg_nxt = in_data;
               w_cnt_nxt   = 5'd0;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_out_xfer && (r_cnt == 5'd31)) begin
               // End of word: reload from hold first, else take a bypassing input.
               if (r_hold_full) begin
                  w_shreg_nxt     = r_hold;
                  w_hold_full_nxt = 1'b0;
                  w_cnt_nxt       = 5'd0;
               end else if (w_in_xfer) begin
                  w_shreg_nxt = in_data;
                  w_cnt_nxt   = 5'd0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               if (w_out_xfer) begin
                  w_shreg_nxt = w_shifted;
                  w_cnt_nxt   = r_cnt + 5'd1;
               end
               if (w_in_xfer) begin
                  w_hold_nxt      = in_data;
                  w_hold_full_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb__serializer32.sv
// Directed bench for _serializer32: one MSB-first and one LSB-first instance,
// an expected bit queue checked at the falling edge, and a summary line.
module tb__serializer32;

   logic        clk;
   logic        reset;
   logic        in_valid_m, in_valid_l;
   logic [31:0] in_data;
   logic        ser_ready;
   logic        in_ready_m, ser_valid_m, ser_out_m, ser_last_m, busy_m, dbg_m;
   logic        in_ready_l, ser_valid_l, ser_out_l, ser_last_l, busy_l, dbg_l;

   int          n_checks = 0;
   int          n_errors = 0;
   logic        sel_l = 1'b0;
   logic [1:0]  exp_q[$];   // {last, bit}
   logic [1:0]  exp_e;
   logic        cur_valid, cur_out, cur_last;

   _serializer32 #(.MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .in_valid(in_valid_m), .in_data(in_data),
      .in_ready(in_ready_m), .ser_valid(ser_valid_m), .ser_out(ser_out_m),
      .ser_last(ser_last_m), .ser_ready(ser_ready), .busy(busy_m),
      .o_dbg_state(dbg_m));

   _serializer32 #(.MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .in_valid(in_valid_l), .in_data(in_data),
      .in_ready(in_ready_l), .ser_valid(ser_valid_l), .ser_out(ser_out_l),
      .ser_last(ser_last_l), .ser_ready(ser_ready), .busy(busy_l),
      .o_dbg_state(dbg_l));

   assign cur_valid = sel_l ? ser_valid_l : ser_valid_m;
   assign cur_out   = sel_l ? ser_out_l   : ser_out_m;
   assign cur_last  = sel_l ? ser_last_l  : ser_last_m;

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected stream: seq[31] is the first bit on the wire.
   task automatic push_seq(input logic [31:0] seq);
      for (int i = 31; i >= 0; i--) exp_q.push_back({(i == 0), seq[i]});
   endtask

   // scoreboard: compare every bit that is transferred
   always @(negedge clk) begin
      if (!reset && cur_valid && ser_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("extra_bit", 32'd1, 32'd0);
         end else begin
            exp_e = exp_q.pop_front();
            check_eq("ser_out", {31'd0, cur_out}, {31'd0, exp_e[0]});
            check_eq("ser_last", {31'd0, cur_last}, {31'd0, exp_e[1]});
         end
      end
   end

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         check_eq({tag, "_valid"}, {31'd0, cur_valid}, 32'd1);
         @(posedge clk); #1;
         n++;
      end
      check_eq({tag, "_drain"}, exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_in_ready"}, {31'd0, in_ready_m}, 32'd1);
      check_eq({tag, "_ser_valid"}, {31'd0, ser_valid_m}, 32'd0);
      check_eq({tag, "_ser_out"}, {31'd0, ser_out_m}, 32'd0);
      check_eq({tag, "_ser_last"}, {31'd0, ser_last_m}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy_m}, 32'd0);
      check_eq({tag, "_state"}, {31'd0, dbg_m}, 32'd0);
   endtask

   // driver: accept one word on the MSB-first instance (called at posedge+1)
   task automatic send_m(input logic [31:0] d);
      in_data    = d;
      in_valid_m = 1'b1;
      @(posedge clk); #1;
      in_valid_m = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid_m = 1'b0; in_valid_l = 1'b0;
      in_data = 32'd0; ser_ready = 1'b1;
      #3;
      check_reset_outs("rst");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // MSB first, single word
      push_seq(32'h1234_5678);
      send_m(32'h1234_5678);
      check_eq("t1_first_valid", {31'd0, ser_valid_m}, 32'd1);
      check_eq("t1_first_bit", {31'd0, ser_out_m}, 32'd0);
      check_eq("t1_busy", {31'd0, busy_m}, 32'd1);
      drain("t1");
      check_eq("t1_end_valid", {31'd0, ser_valid_m}, 32'd0);
      check_eq("t1_end_busy", {31'd0, busy_m}, 32'd0);

      // LSB first on the second instance
      sel_l = 1'b1;
      push_seq(32'b0100_1100_0010_1010_0110_1110_0001_1001);
      in_data = 32'h9876_5432; in_valid_l = 1'b1;
      @(posedge clk); #1;
      in_valid_l = 1'b0;
      check_eq("t2_first_bit", {31'd0, ser_out_l}, 32'd0);
      drain("t2");
      check_eq("t2_end_valid", {31'd0, ser_valid_l}, 32'd0);
      sel_l = 1'b0;

      // Back-to-back through the holding buffer
      push_seq(32'hffee_ddcc);
      push_seq(32'hbbaa_9988);
      send_m(32'hffee_ddcc);
      repeat (5) @(posedge clk);
      #1;
      check_eq("t3_ready_before", {31'd0, in_ready_m}, 32'd1);
      send_m(32'hbbaa_9988);
      check_eq("t3_ready_full", {31'd0, in_ready_m}, 32'd0);
      check_eq("t3_busy", {31'd0, busy_m}, 32'd1);
      repeat (25) @(posedge clk);
      #1;
      check_eq("t3_ready_eow", {31'd0, in_ready_m}, 32'd0);
      check_eq("t3_last_eow", {31'd0, ser_last_m}, 32'd1);
      @(posedge clk); #1;
      check_eq("t3_ready_w2", {31'd0, in_ready_m}, 32'd1);
      check_eq("t3_valid_w2", {31'd0, ser_valid_m}, 32'd1);
      check_eq("t3_bit0_w2", {31'd0, ser_out_m}, 32'd1);
      drain("t3");
      check_eq("t3_end_busy", {31'd0, busy_m}, 32'd0);

      // ser_ready pattern 1,0,0,1 repeating
      push_seq(32'h7766_5544);
      send_m(32'h7766_5544);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         ser_ready = (i % 4 == 0) || (i % 4 == 3);
         check_eq("t4_valid", {31'd0, ser_valid_m}, 32'd1);
         @(posedge clk); #1;
      end
      ser_ready = 1'b1;
      check_eq("t4_drain", exp_q.size(), 32'd0);
      check_eq("t4_end_valid", {31'd0, ser_valid_m}, 32'd0);

      // Bypass: next word presented while ser_last is high, hold empty
      push_seq(32'h1234_5678);
      push_seq(32'h3322_1100);
      send_m(32'h1234_5678);
      repeat (31) @(posedge clk);
      #1;
      check_eq("t5_last", {31'd0, ser_last_m}, 32'd1);
      check_eq("t5_ready", {31'd0, in_ready_m}, 32'd1);
      send_m(32'h3322_1100);
      check_eq("t5_valid_w2", {31'd0, ser_valid_m}, 32'd1);
      check_eq("t5_last_w2", {31'd0, ser_last_m}, 32'd0);
      check_eq("t5_ready_w2", {31'd0, in_ready_m}, 32'd1);
      drain("t5");
      check_eq("t5_end_valid", {31'd0, ser_valid_m}, 32'd0);

      // Asynchronous reset mid-word with hold full
      push_seq(32'h1234_5678);
      send_m(32'h1234_5678);
      send_m(32'hbbaa_9988);
      check_eq("t6_hold_full", {31'd0, in_ready_m}, 32'd0);
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check_reset_outs("t6_async");
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_outs("t6_release");
      push_seq(32'h9876_5432);
      send_m(32'h9876_5432);
      check_eq("t6_first_bit", {31'd0, ser_out_m}, 32'd1);
      drain("t6");
      check_eq("t6_end_busy", {31'd0, busy_m}, 32'd0);

      // report
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
